// File: rtl/softmax_result_writer_pkg.sv
// Shared definitions for the softmax result writer.
// Holds the default element/lane/address widths used by the softmax core,
// the writer FSM state encoding and the output address helper.
package softmax_result_writer_pkg;

  localparam int SMX_DATAWIDTH = 16;  // fp16 element width
  localparam int SMX_NUM       = 2;   // lanes per packed result word
  localparam int SMX_ADDRSIZE  = 16;  // output memory address width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } wr_state_e;

  // Output address for the off-th word of a run; wraps modulo 2**ADDRSIZE.
  function automatic logic [SMX_ADDRSIZE-1:0] out_addr(
    input logic [SMX_ADDRSIZE-1:0] base,
    input logic [SMX_ADDRSIZE-1:0] off
  );
    return base + off;
  endfunction

endpackage

// File: rtl/softmax_result_writer_result_fifo.sv
// result_fifo: synchronous FIFO buffering packed result words.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   clear_i         - synchronous flush (drops all buffered entries)
//   push_i, wdata_i - write one entry (caller guarantees not full, or pop_i)
//   pop_i           - remove head entry (caller guarantees not empty)
//   full_o, empty_o - occupancy status from registered state
//   head_o          - current head entry
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/softmax_result_writer.sv
// softmax_result_writer: captures packed fp16 result words strobed by the
// softmax core, buffers them in a FIFO and writes them to sequential output
// memory addresses over a ready/valid write port, then pulses complete.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   init, out_start_addr,
//   num_words                - start (or restart) a run: base address, length
//   in_valid, in_data        - result strobe and word from the core (no stall)
//   wr_en, wr_addr, wr_data,
//   wr_ready                 - output memory write port
//   busy, complete           - run in progress / one-cycle end-of-run pulse
//   overflow, excess         - sticky: word dropped on full FIFO / stray word
module softmax_result_writer
  import softmax_result_writer_pkg::*;
#(
  parameter int DATAWIDTH  = SMX_DATAWIDTH,
  parameter int NUM        = SMX_NUM,
  parameter int ADDRSIZE   = SMX_ADDRSIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [ADDRSIZE-1:0]     out_start_addr,
  input  logic [ADDRSIZE-1:0]     num_words,
  input  logic                    in_valid,
  input  logic [DATAWIDTH*NUM-1:0] in_data,
  output logic                    wr_en,
  output logic [ADDRSIZE-1:0]     wr_addr,
  output logic [DATAWIDTH*NUM-1:0] wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    complete,
  output logic                    overflow,
  output logic                    excess
);

  localparam int WW = DATAWIDTH * NUM;

  wr_state_e         state_q, state_d;
  logic [ADDRSIZE-1:0] base_q, base_d;
  logic [ADDRSIZE-1:0] len_q, len_d;
  logic [ADDRSIZE-1:0] acc_cnt_q, acc_cnt_d;
  logic [ADDRSIZE-1:0] wr_cnt_q, wr_cnt_d;
  logic              overflow_q, overflow_d;
  logic              excess_q, excess_d;

  logic              fifo_full, fifo_empty, fifo_clear;
  logic [WW-1:0]     fifo_head;
  logic              in_run, wr_req, pop, push_req, push, drop, stray, last_write;

  result_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (fifo_clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign in_run = (state_q == RUN);

  // A write is never requested while reset is high, nor in a cycle where
  // init aborts the run (its buffered words are being discarded).
  assign wr_req     = in_run & ~fifo_empty & ~reset & ~init;
  assign pop        = wr_req & wr_ready;
  assign last_write = pop & ((wr_cnt_q + ADDRSIZE'(1)) == len_q);

  // Pushing into a full FIFO is legal only when the head leaves this cycle,
  // so no bypass path from in_data to wr_data is ever needed.
  assign push_req = in_valid & in_run & (acc_cnt_q < len_q) & ~init;
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;
  assign stray    = in_valid & ~init & (~in_run | (acc_cnt_q == len_q));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    acc_cnt_d  = acc_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    overflow_d = overflow_q;
    excess_d   = excess_q;
    fifo_clear = 1'b0;
    if (init) begin
      // Start or abort-and-restart: identical from every state.
      base_d     = out_start_addr;
      len_d      = num_words;
      acc_cnt_d  = '0;
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
      excess_d   = 1'b0;
      fifo_clear = 1'b1;
      state_d    = (num_words == '0) ? FIN : RUN;
    end else begin
      if (push)  acc_cnt_d  = acc_cnt_q + ADDRSIZE'(1);
      if (pop)   wr_cnt_d   = wr_cnt_q + ADDRSIZE'(1);
      if (drop)  overflow_d = 1'b1;
      if (stray) excess_d   = 1'b1;
      unique case (state_q)
        RUN:     if (last_write) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      overflow_q <= 1'b0;
      excess_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      overflow_q <= overflow_d;
      excess_q   <= excess_d;
    end
  end

  // Outputs read as their reset values while reset is held. wr_data is
  // zeroed when no write is requested so stale FIFO storage never shows;
  // during a stall it stays on the unchanged head entry.
  assign wr_en    = wr_req;
  assign wr_addr  = reset ? '0 : out_addr(base_q, wr_cnt_q);
  assign wr_data  = wr_req ? fifo_head : '0;
  assign busy     = in_run & ~reset;
  assign complete = (state_q == FIN) & ~reset;
  assign overflow = overflow_q & ~reset;
  assign excess   = excess_q & ~reset;

endmodule

// File: tb/tb_softmax_result_writer.sv
module tb_softmax_result_writer;

  localparam int DW = 16;
  localparam int NL = 2;
  localparam int AW = 16;
  localparam int WW = DW * NL;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [AW-1:0] out_start_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          wr_ready = 1'b0;
  logic          busy, complete, overflow, excess;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  int completes = 0;
  exp_t sb[$];
  exp_t mon_e;

  softmax_result_writer #(
    .DATAWIDTH (DW),
    .NUM       (NL),
    .ADDRSIZE  (AW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .out_start_addr(out_start_addr),
    .num_words     (num_words),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .complete      (complete),
    .overflow      (overflow),
    .excess        (excess)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (complete) completes++;
    if (wr_en && wr_ready) begin
      writes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_write unexpected write addr=%h data=%h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [AW-1:0] base, input logic [AW-1:0] len);
    out_start_addr = base;
    num_words      = len;
    init           = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, complete, overflow, excess} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr_en=%b addr=%h data=%h busy=%b cpl=%b ovf=%b exc=%b expected all 0",
               wr_en, wr_addr, wr_data, busy, complete, overflow, excess);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [WW-1:0] d[4];
    int w0, c0;
    d[0] = 32'h3C00_4000; d[1] = 32'h3800_3C00; d[2] = 32'h0000_3C00; d[3] = 32'h3555_3555;
    w0 = writes; c0 = completes;
    wr_ready = 1'b1;
    do_init(16'h0100, 16'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      sb.push_back('{addr: 16'(16'h0100 + i), data: d[i]});
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
        errors++;
        $display("FAIL basic_no_bypass word %0d got wr_en=%b expected 0", i, wr_en);
      end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== d[i] || wr_addr !== 16'(16'h0100 + i)) begin
        errors++;
        $display("FAIL basic_latency word %0d got wr_en=%b addr=%h data=%h expected 1 %h %h",
                 i, wr_en, wr_addr, wr_data, 16'(16'h0100 + i), d[i]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (complete !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_complete got complete=%b busy=%b expected 1 0", complete, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (complete !== 1'b0 || completes - c0 != 1 || writes - w0 != 4) begin
      errors++;
      $display("FAIL basic_counts got complete=%b pulses=%0d writes=%0d expected 0 1 4",
               complete, completes - c0, writes - w0);
    end
    checks++;
    if (overflow !== 1'b0 || excess !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got ovf=%b exc=%b expected 0 0", overflow, excess);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [WW-1:0] d[8];
    int w0, c0;
    bit seen;
    for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(i * 16'h0101);
    w0 = writes; c0 = completes;
    wr_ready = 1'b0;
    do_init(16'h0100, 16'd6);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      if (i < 4) sb.push_back('{addr: 16'(16'h0100 + i), data: d[i]});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got overflow=%b expected 1", overflow);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h0100 || wr_data !== d[0]) begin
        errors++;
        $display("FAIL ovf_stall_hold cycle %0d got wr_en=%b addr=%h data=%h expected 1 0100 %h",
                 k, wr_en, wr_addr, wr_data, d[0]);
      end
    end
    tick();
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    checks++;
    if (writes - w0 != 4 || wr_en !== 1'b0 || busy !== 1'b1 || complete !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got writes=%0d wr_en=%b busy=%b cpl=%b expected 4 0 1 0",
               writes - w0, wr_en, busy, complete);
    end
    tick();
    for (int i = 6; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      sb.push_back('{addr: 16'(16'h0100 + i - 2), data: d[i]});
      tick();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen || writes - w0 != 6 || completes - c0 != 1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_finish got seen=%b writes=%0d pulses=%0d ovf=%b expected 1 6 1 1",
               seen, writes - w0, completes - c0, overflow);
    end
  endtask

  task automatic test_excess();
    int w0, c0;
    bit seen;
    w0 = writes; c0 = completes;
    wr_ready = 1'b1;
    do_init(16'h0400, 16'd2);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_0000 + 32'(i);
      if (i < 2) sb.push_back('{addr: 16'(16'h0400 + i), data: 32'h1234_0000 + 32'(i)});
      tick();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen || writes - w0 != 2 || completes - c0 != 1) begin
      errors++;
      $display("FAIL excess_run got seen=%b writes=%0d pulses=%0d expected 1 2 1",
               seen, writes - w0, completes - c0);
    end
    @(negedge clk);
    checks++;
    if (excess !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL excess_flag got exc=%b ovf=%b expected 1 0", excess, overflow);
    end
    tick();
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = writes;
    wr_ready = 1'b1;
    do_init(16'h0500, 16'd0);
    @(negedge clk);
    checks++;
    if (complete !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_complete got cpl=%b busy=%b wr_en=%b expected 1 0 0", complete, busy, wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (complete !== 1'b0 || wr_en !== 1'b0 || writes != w0) begin
      errors++;
      $display("FAIL zero_after got cpl=%b wr_en=%b writes=%0d expected 0 0 0", complete, wr_en, writes - w0);
    end
    tick();
  endtask

  task automatic test_wrap();
    int w0;
    bit seen;
    w0 = writes;
    wr_ready = 1'b1;
    do_init(16'hFFFF, 16'd3);
    sb.push_back('{addr: 16'hFFFF, data: 32'h0001_0001});
    sb.push_back('{addr: 16'h0000, data: 32'h0002_0002});
    sb.push_back('{addr: 16'h0001, data: 32'h0003_0003});
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = {16'(i), 16'(i)};
      tick();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen || writes - w0 != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_run got seen=%b writes=%0d pending=%0d expected 1 3 0",
               seen, writes - w0, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit seen;
    w0 = writes;
    wr_ready = 1'b1;
    do_init(16'h0200, 16'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h5500_0000 + 32'(i);
      sb.push_back('{addr: 16'(16'h0200 + i), data: 32'h5500_0000 + 32'(i)});
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    checks++;
    if (writes - w0 != 2) begin
      errors++;
      $display("FAIL rstmid_before got writes=%0d expected 2", writes - w0);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, complete, overflow, excess} !== '0) begin
      errors++;
      $display("FAIL rstmid_during got wr_en=%b addr=%h data=%h busy=%b cpl=%b ovf=%b exc=%b expected all 0",
               wr_en, wr_addr, wr_data, busy, complete, overflow, excess);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, complete, overflow, excess} !== '0) begin
      errors++;
      $display("FAIL rstmid_after got wr_en=%b addr=%h data=%h busy=%b cpl=%b ovf=%b exc=%b expected all 0",
               wr_en, wr_addr, wr_data, busy, complete, overflow, excess);
    end
    tick();
    w0 = writes;
    do_init(16'h0300, 16'd2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || overflow !== 1'b0 || excess !== 1'b0 || wr_addr !== 16'h0300) begin
      errors++;
      $display("FAIL rstmid_restart got busy=%b wr_en=%b ovf=%b exc=%b addr=%h expected 1 0 0 0 0300",
               busy, wr_en, overflow, excess, wr_addr);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h6600_0000 + 32'(i);
      sb.push_back('{addr: 16'(16'h0300 + i), data: 32'h6600_0000 + 32'(i)});
      tick();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (complete) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen || writes - w0 != 2) begin
      errors++;
      $display("FAIL rstmid_newrun got seen=%b writes=%0d expected 1 2", seen, writes - w0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_excess();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending writes expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_result_writer.md
Name: softmax_result_writer

Overview:
- Downstream stage of the softmax core. It captures each packed result word (NUM fp16 lanes) that the core emits through its done/outp strobe.
- Words are buffered in a small FIFO and written to the output on-chip memory at sequential addresses through a ready/valid write port.
- When the programmed number of words has been written, the block signals completion.
- The softmax core cannot be stalled, so FIFO overrun is detected and flagged, never back-pressured.

Parameters:
DATAWIDTH, 16, width of one fp16 element (sign+exponent+mantissa)
NUM, 2, lanes per result word
ADDRSIZE, 16, output memory address width
FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high; clears all state
init  in  1  one-cycle pulse; latches out_start_addr and num_words, enters RUN
out_start_addr  in  ADDRSIZE  first output memory address
num_words  in  ADDRSIZE  number of packed words to write for this softmax run
in_valid  in  1  result strobe from the softmax core (its done output)
in_data  in  DATAWIDTH*NUM  {outp1,outp0}; lane 0 in the low bits
wr_en  out  1  write request to the output memory
wr_addr  out  ADDRSIZE  write address
wr_data  out  DATAWIDTH*NUM  write data, equal to the FIFO head
wr_ready  in  1  memory accepts the write this cycle when high together with wr_en
busy  out  1  high while in RUN
complete  out  1  one-cycle pulse after the final write
overflow  out  1  sticky; a word was dropped on a full FIFO
excess  out  1  sticky; in_valid seen outside RUN or after num_words words accepted

Behaviour:
- Interface clocking: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, complete=0, overflow=0, excess=0. FIFO is empty, all counters are 0, state is IDLE.
- States: IDLE, RUN, FIN.
- IDLE, init=1: latch base and len, clear acc_cnt/wr_cnt/FIFO/overflow/excess. Go to FIN if num_words==0, else RUN.
- RUN, wr_cnt reaching len on a write handshake: go to FIN.
- FIN: complete=1 for exactly one cycle, then IDLE.
- init asserted in RUN or FIN: abort and restart exactly as from IDLE. Buffered words are discarded; no complete pulse for the aborted run.
- Push condition: in_valid & state==RUN & acc_cnt<len.
  - Word accepted if the FIFO is not full, or a pop occurs in the same cycle. Then acc_cnt increments.
  - Full with no pop: word dropped, overflow<=1, acc_cnt unchanged.
- in_valid outside RUN, or with acc_cnt==len: word ignored, excess<=1.
- Pop/write: wr_en = (state==RUN) & FIFO not empty, combinational from the registered FIFO state.
  - wr_data = head entry; wr_addr = base + wr_cnt, ADDRSIZE-bit modulo (wraps silently).
  - Handshake wr_en & wr_ready: pop, wr_cnt++.
  - wr_data and wr_addr are held stable while wr_en=1 & wr_ready=0.
- Latency: a word pushed at edge t is presented with wr_en=1 in cycle t+1 (FIFO empty, no earlier words pending). Throughput is 1 word/cycle with wr_ready held high.
- Simultaneous push and pop on an empty FIFO: not allowed to bypass; the word appears in the next cycle.
- Simultaneous push and pop on a full FIFO: both occur; occupancy is unchanged.
- Counters are ADDRSIZE bits wide; the occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Sticky flags clear only on reset or init.
- reset mid-operation: everything returns to reset values in the next cycle; no write is issued in the cycle reset is high.

Decomposition:
- Shared defines include: DATAWIDTH, NUM, ADDRSIZE (same macros as the softmax core) and a state encoding: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
- One sub-module, result_fifo: synchronous FIFO with push, pop, full, empty, head, parameterised on width and depth.
- The top level holds the FSM, counters, address generation and flags.

Test Plan:
1. init with out_start_addr=0x0100, num_words=4; four in_valid pulses with data 0x3C00_4000, 0x3800_3C00, 0x0000_3C00, 0x3555_3555; wr_ready=1 -> writes to 0x0100..0x0103 in order, each one cycle after its push. complete pulses once, the cycle after the 4th write. overflow=0, excess=0.
2. Same setup with wr_ready=0 for 10 cycles and 6 back-to-back pushes, FIFO_DEPTH=4 -> first 4 words buffered, overflow=1. When wr_ready rises, 4 writes occur and acc_cnt stays 4 until two more valid words arrive.
3. num_words=2 with 3 pushes -> 2 writes, excess=1, complete after the second write.
4. num_words=0 -> complete pulses the cycle after init; no wr_en ever asserted.
5. out_start_addr=0xFFFF, num_words=3 -> writes to 0xFFFF, 0x0000, 0x0001.
6. reset asserted after 2 of 4 writes, then init again -> all outputs 0 during and after reset. The new run starts at the new base with clear flags and no stale words.
